// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - node word layout, FSM states and float ordering key for tree_walker
package tree_pkg;

  localparam int LEAF_CLASS_LSB = 0;
  localparam int LEAF_CLASS_W   = 4;
  localparam int RIGHT_LSB      = 4;
  localparam int LEFT_LSB       = 16;
  localparam int CHILD_W        = 12;
  localparam int THR_LSB        = 28;
  localparam int THR_W          = 32;
  localparam int FEAT_IDX_LSB   = 60;
  localparam int FEAT_IDX_W     = 4;
  localparam int IS_LEAF_BIT    = 64;
  localparam int DEPTH_W        = 6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL,
    DONE
  } state_t;

  // Maps IEEE-754 single bit patterns onto an unsigned order: negatives flip fully, positives flip the sign.
  function automatic logic [31:0] float_key(input logic [31:0] x);
    return x[31] ? ~x : {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/tree_node_eval.sv
// rtl/tree_node_eval.sv - combinational node decode, feature select, threshold compare and child/error generation
module tree_node_eval
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 32,
  parameter int CLASS_WIDTH  = 4
) (
  input  logic [NODE_WIDTH-1:0]              i_node,
  input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] i_features,
  output logic                               o_is_leaf,
  output logic [CLASS_WIDTH-1:0]             o_leaf_class,
  output logic [ADDR_WIDTH-1:0]              o_next_addr,
  output logic                               o_node_error
);

  localparam int FEAT_SLOTS = 1 << FEAT_IDX_W;
  localparam logic [FEAT_SLOTS-1:0] FEAT_MASK =
    FEAT_SLOTS'((FEAT_SLOTS+1)'(1) << NUM_FEATURES) - FEAT_SLOTS'(1);

  logic [CHILD_W-1:0]    w_left;
  logic [CHILD_W-1:0]    w_right;
  logic [CHILD_W-1:0]    w_child;
  logic [FEAT_IDX_W-1:0] w_feat_idx;
  logic [THR_W-1:0]      w_thr;
  logic [FEAT_WIDTH-1:0] w_feat;
  logic [FEAT_SLOTS-1:0] w_feat_mask;
  logic                  w_go_left;
  logic                  w_child_bad;
  logic                  w_feat_bad;
  logic                  w_unused_bits;

  assign o_is_leaf     = i_node[IS_LEAF_BIT];
  assign o_leaf_class  = i_node[LEAF_CLASS_LSB +: CLASS_WIDTH];
  assign w_right       = i_node[RIGHT_LSB +: CHILD_W];
  assign w_left        = i_node[LEFT_LSB +: CHILD_W];
  assign w_thr         = i_node[THR_LSB +: THR_W];
  assign w_feat_idx    = i_node[FEAT_IDX_LSB +: FEAT_IDX_W];
  assign w_unused_bits = ^i_node[NODE_WIDTH-1:IS_LEAF_BIT+1];
  assign w_feat_mask   = FEAT_MASK;

  always_comb begin
    w_feat = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (w_feat_idx == FEAT_IDX_W'(i)) w_feat = i_features[i*FEAT_WIDTH +: FEAT_WIDTH];
    end
  end

  assign w_go_left    = float_key(w_feat) <= float_key(w_thr);
  assign w_child      = w_go_left ? w_left : w_right;
  assign w_child_bad  = (w_child == '0) || (w_child >= CHILD_W'(ROM_DEPTH));
  assign w_feat_bad   = !w_feat_mask[w_feat_idx];
  assign o_next_addr  = w_child[ADDR_WIDTH-1:0];
  assign o_node_error = w_child_bad | w_feat_bad;

endmodule

// File: rtl/tree_walker.sv
// rtl/tree_walker.sv - decision-tree traversal engine driving a synchronous node ROM.
// Optional TREE_WALKER_PROFILE_EN adds res_depth and a saturating completed-walk counter.
module tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 32,
  parameter int MAX_DEPTH    = 32,
  parameter int CLASS_WIDTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
  output logic                               busy,
  output logic [ADDR_WIDTH-1:0]              rom_addr,
  input  logic [NODE_WIDTH-1:0]              node_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [CLASS_WIDTH-1:0]             res_class,
  output logic                               res_error
`ifdef TREE_WALKER_PROFILE_EN
  ,
  output logic [DEPTH_W-1:0]                 res_depth
`endif
);

  state_t                            r_state, w_state_nxt;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] r_features, w_features_nxt;
  logic [ADDR_WIDTH-1:0]             r_rom_addr, w_rom_addr_nxt;
  logic [DEPTH_W-1:0]                r_depth, w_depth_nxt;
  logic [CLASS_WIDTH-1:0]            r_class, w_class_nxt;
  logic                              r_error, w_error_nxt;

  logic                              w_is_leaf;
  logic [CLASS_WIDTH-1:0]            w_leaf_class;
  logic [ADDR_WIDTH-1:0]             w_next_addr;
  logic                              w_node_error;
  logic [DEPTH_W-1:0]                w_depth_inc;
  logic                              w_depth_over;

  tree_node_eval #(
    .NODE_WIDTH  (NODE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .ROM_DEPTH   (ROM_DEPTH),
    .NUM_FEATURES(NUM_FEATURES),
    .FEAT_WIDTH  (FEAT_WIDTH),
    .CLASS_WIDTH (CLASS_WIDTH)
  ) u_node_eval (
    .i_node      (node_data),
    .i_features  (r_features),
    .o_is_leaf   (w_is_leaf),
    .o_leaf_class(w_leaf_class),
    .o_next_addr (w_next_addr),
    .o_node_error(w_node_error)
  );

  assign w_depth_inc  = r_depth + DEPTH_W'(1);
  assign w_depth_over = w_depth_inc >= DEPTH_W'(MAX_DEPTH);

  always_comb begin
    w_state_nxt    = r_state;
    w_features_nxt = r_features;
    w_rom_addr_nxt = r_rom_addr;
    w_depth_nxt    = r_depth;
    w_class_nxt    = r_class;
    w_error_nxt    = r_error;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_features_nxt = features;
          w_rom_addr_nxt = '0;
          w_depth_nxt    = '0;
          w_class_nxt    = '0;
          w_error_nxt    = 1'b0;
          w_state_nxt    = FETCH;
        end
      end
      FETCH: w_state_nxt = EVAL;
      EVAL: begin
        w_depth_nxt = w_depth_inc;
        if (w_is_leaf) begin
          w_class_nxt = w_leaf_class;
          w_error_nxt = 1'b0;
          w_state_nxt = DONE;
        end else if (w_node_error || w_depth_over) begin
          w_class_nxt = '0;
          w_error_nxt = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_rom_addr_nxt = w_next_addr;
          w_state_nxt    = FETCH;
        end
      end
      DONE: begin
        // A start coinciding with the handshake is deliberately dropped.
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_features <= '0;
      r_rom_addr <= '0;
      r_depth    <= '0;
      r_class    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_features <= w_features_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_depth    <= w_depth_nxt;
      r_class    <= w_class_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign rom_addr  = r_rom_addr;
  assign res_class = r_class;
  assign res_error = r_error;

`ifdef TREE_WALKER_PROFILE_EN
  logic [15:0] r_walk_count;

  assign res_depth = r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_walk_count <= '0;
    end else if (r_state == EVAL && w_state_nxt == DONE && r_walk_count != 16'hFFFF) begin
      r_walk_count <= r_walk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tree_walker.sv
// tb/tb_tree_walker.sv - directed and randomized walks of tree_walker against a behavioural tree model
module tb_tree_walker;

  localparam int NF = 16;
  localparam int FW = 32;
  localparam int NW = 120;
  localparam int AW = 10;
  localparam int RD = 512;
  localparam int MD = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              res_ready = 1'b0;
  logic [NF*FW-1:0]  features = '0;
  logic              busy;
  logic [AW-1:0]     rom_addr;
  logic [NW-1:0]     node_data;
  logic              res_valid;
  logic [3:0]        res_class;
  logic              res_error;
`ifdef TREE_WALKER_PROFILE_EN
  logic [5:0]        res_depth;
`endif

  logic [NW-1:0] rom [RD];
  int n_checks = 0;
  int n_fail   = 0;
  int m_class  = 0;
  int m_err    = 0;
  int m_depth  = 0;

  tree_walker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .features (features),
    .busy     (busy),
    .rom_addr (rom_addr),
    .node_data(node_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_class(res_class),
    .res_error(res_error)
`ifdef TREE_WALKER_PROFILE_EN
    ,
    .res_depth(res_depth)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) node_data <= rom[rom_addr[8:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk_leaf(input int cls);
    logic [NW-1:0] n;
    n = '0;
    n[64] = 1'b1;
    n[3:0] = 4'(cls);
    return n;
  endfunction

  function automatic logic [NW-1:0] mk_int(input int fi, input logic [31:0] thr, input int l, input int r);
    logic [NW-1:0] n;
    n = '0;
    n[63:60] = 4'(fi);
    n[59:28] = thr;
    n[27:16] = 12'(l);
    n[15:4]  = 12'(r);
    return n;
  endfunction

  function automatic logic [NF*FW-1:0] mkf(input int idx, input logic [31:0] val);
    logic [NF*FW-1:0] f;
    f = '0;
    f[idx*FW +: FW] = val;
    return f;
  endfunction

  // a <= b as real numbers in sign-magnitude order, with -0 strictly below +0
  function automatic bit le_float(input logic [31:0] a, input logic [31:0] b);
    if (a == b) return 1'b1;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  task automatic model_walk(input logic [NF*FW-1:0] f, output int cls, output int err, output int depth);
    int addr, fi, child;
    bit fin;
    logic [NW-1:0] n;
    addr = 0; cls = 0; err = 0; depth = 0; fin = 0;
    while (!fin) begin
      n = rom[addr];
      depth++;
      if (n[64]) begin
        cls = int'(n[3:0]);
        fin = 1;
      end else begin
        fi = int'(n[63:60]);
        child = le_float(f[fi*FW +: FW], n[59:28]) ? int'(n[27:16]) : int'(n[15:4]);
        if (fi >= NF || child == 0 || child >= RD || depth >= MD) begin
          err = 1;
          fin = 1;
        end else begin
          addr = child;
        end
      end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_walk(input string name, input logic [NF*FW-1:0] f,
                          input int lit_cls, input int lit_err, input int lit_lat);
    int lat, c, e, d;
    model_walk(f, c, e, d);
    if (lit_cls >= 0) begin
      check({name, " model class"}, c, lit_cls);
      check({name, " model error"}, e, lit_err);
      check({name, " model latency"}, 2 * d + 1, lit_lat);
    end
    @(negedge clk);
    m_class = c; m_err = e; m_depth = d;
    features = f;
    start = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NF; k++) features[k*FW +: FW] = $urandom;
    check({name, " busy after start"}, busy, 1);
    wait_valid(lat);
    check({name, " latency"}, lat, 2 * d + 1);
    if (res_valid) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({name, " valid drop"}, res_valid, 0);
      check({name, " idle busy"}, busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      check("cmp class", res_class, m_class);
      check("cmp error", res_error, m_err);
      check("cmp busy", busy, 1);
`ifdef TREE_WALKER_PROFILE_EN
      check("cmp depth", res_depth, m_depth);
`endif
    end
  end

  task automatic rand_rom();
    int p;
    for (int i = 0; i < RD; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        rom[i] = mk_leaf($urandom_range(0, 15));
      end else begin
        int l, r;
        p = $urandom_range(0, 99);
        l = (p < 3) ? 0 : (p < 6) ? $urandom_range(512, 4095) : $urandom_range(1, 511);
        p = $urandom_range(0, 99);
        r = (p < 3) ? 0 : (p < 6) ? $urandom_range(512, 4095) : $urandom_range(1, 511);
        rom[i] = mk_int($urandom_range(0, 15), $urandom, l, r);
      end
    end
  endtask

  task automatic three_level(input logic [31:0] thr);
    for (int i = 0; i < RD; i++) rom[i] = mk_leaf(0);
    rom[0] = mk_int(2, thr, 1, 2);
    rom[1] = mk_leaf(3);
    rom[2] = mk_leaf(9);
  endtask

  initial begin
    int lat;
    logic [NF*FW-1:0] f;
    for (int i = 0; i < RD; i++) rom[i] = mk_leaf(0);

    #1;
    check("reset busy", busy, 0);
    check("reset valid", res_valid, 0);
    check("reset addr", rom_addr, 0);
    check("reset class", res_class, 0);
    check("reset error", res_error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    rom[0] = mk_leaf(5);
    run_walk("root leaf", '0, 5, 0, 3);

    three_level(32'h40000000);
    run_walk("feat 1.0", mkf(2, 32'h3F800000), 3, 0, 5);
    run_walk("feat -3.0", mkf(2, 32'hC0400000), 3, 0, 5);
    run_walk("feat 3.0", mkf(2, 32'h40400000), 9, 0, 5);
    run_walk("feat equal", mkf(2, 32'h40000000), 3, 0, 5);
    run_walk("feat equal+1", mkf(2, 32'h40000001), 9, 0, 5);
    three_level(32'h00000000);
    run_walk("neg zero", mkf(2, 32'h80000000), 3, 0, 5);
    three_level(32'h80000000);
    run_walk("pos zero", mkf(2, 32'h00000000), 9, 0, 5);
    three_level(32'hC0000000);
    run_walk("neg neg", mkf(2, 32'hC0400000), 3, 0, 5);

    rom[0] = mk_int(2, 32'h40000000, 0, 2);
    run_walk("left zero", mkf(2, 32'h3F800000), 0, 1, 3);
    rom[0] = mk_int(2, 32'h40000000, 1, 512);
    run_walk("child 512", mkf(2, 32'h40400000), 0, 1, 3);
    rom[0] = mk_int(0, 32'h7F000000, 1, 2);
    rom[1] = mk_int(0, 32'h7F000000, 1, 2);
    run_walk("self loop", '0, 0, 1, 65);

    three_level(32'h40000000);
    f = mkf(2, 32'h40400000);
    model_walk(f, m_class, m_err, m_depth);
    @(negedge clk);
    features = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat);
    check("bp latency", lat, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b1;
      features = mkf(2, 32'h3F800000);
      check("bp busy", busy, 1);
      check("bp valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check("bp release valid", res_valid, 0);
    check("bp release busy", busy, 0);
    @(negedge clk);
    check("start at handshake ignored", busy, 0);

    @(negedge clk);
    features = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset addr", rom_addr, 2);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset addr", rom_addr, 0);
    check("mid reset valid", res_valid, 0);
    check("mid reset class", res_class, 0);
    check("mid reset error", res_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_walk("after reset", mkf(2, 32'h3F800000), 3, 0, 5);

    for (int it = 0; it < 150; it++) begin
      if (it % 5 == 0) rand_rom();
      for (int k = 0; k < NF; k++) f[k*FW +: FW] = $urandom;
      if ($urandom_range(0, 3) == 0 && !rom[0][64])
        f[int'(rom[0][63:60])*FW +: FW] = rom[0][59:28];
      run_walk("random", f, -1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tree_walker.md
Name: tree_walker

Overview:
- Traversal engine that drives the address port of a per-tree node ROM (`tree_rom_N`) and consumes its 120-bit `node_data`.
- Latches one feature vector on `start`, walks from the root (address 0) to a leaf, and returns the leaf class through a valid/ready result handshake.
- One instance sits in front of each tree ROM; a vote stage downstream combines the per-tree classes.

Parameters:
- NODE_WIDTH, 120, width of a ROM node word
- ADDR_WIDTH, 10, ROM address width
- ROM_DEPTH, 512, number of valid node locations; a child index >= ROM_DEPTH is an error
- NUM_FEATURES, 16, number of features in the input vector
- FEAT_WIDTH, 32, feature width (IEEE-754 single)
- MAX_DEPTH, 32, maximum node visits before the walk aborts
- CLASS_WIDTH, 4, leaf class width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a walk; accepted only when busy=0
- features  in  NUM_FEATURES*FEAT_WIDTH  feature vector; feature i occupies bits [i*32 +: 32]; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the result is consumed
- rom_addr  out  ADDR_WIDTH  address to the node ROM
- node_data  in  NODE_WIDTH  synchronous ROM read data; valid one cycle after rom_addr
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_class  out  CLASS_WIDTH  leaf class
- res_error  out  1  walk aborted (depth exceeded, bad child, or bad feature index)

Behaviour:
- Node layout (package constants):
  - leaf_class [3:0]
  - right_child [15:4]
  - left_child [27:16]
  - threshold [59:28]
  - feat_idx [63:60]
  - is_leaf [64]
  - remaining bits are ignored.
- Reset values: busy=0, rom_addr=0, res_valid=0, res_class=0, res_error=0, depth=0, state=IDLE.
- States:
  - IDLE: on start, latch features, drive rom_addr=0, depth=0, go to FETCH.
  - FETCH: one cycle covering the ROM read latency; go to EVAL.
  - EVAL: node_data is valid; depth increments.
    - If is_leaf: res_class=leaf_class, res_error=0, go to DONE.
    - Otherwise select the child and drive rom_addr=child[ADDR_WIDTH-1:0], go to FETCH.
  - DONE: res_valid=1, outputs held stable until res_ready; on res_valid&&res_ready go to IDLE, res_valid drops the next cycle.
- Child selection:
  - Take left_child if key(feature[feat_idx]) <= key(threshold), else right_child.
  - key(x) is an order-preserving transform: if the sign bit is set, invert all bits; otherwise invert only the sign bit. Compare the keys as unsigned.
  - -0 and +0 differ by one step; NaN follows bit order (unsupported).
- Latency: 2 cycles per visited node. A root-leaf tree gives res_valid 3 cycles after start (IDLE→FETCH→EVAL→DONE).
- Error conditions, checked in EVAL on internal nodes; each goes to DONE with res_error=1 and res_class=0:
  - child index == 0 or >= ROM_DEPTH.
  - feat_idx >= NUM_FEATURES.
  - depth reaching MAX_DEPTH without a leaf.
- start while busy is ignored; features are not re-sampled.
- start in the same cycle as the DONE handshake is ignored; it must be reissued once busy=0.
- Asserting rst_n low mid-walk returns to IDLE and clears all outputs immediately; no partial result is produced.
- rom_addr holds its value in IDLE and DONE.

Optional Feature:
- TREE_WALKER_PROFILE_EN defined:
  - Adds output res_depth [5:0]: number of nodes visited in the completed walk, valid with res_valid.
  - Adds a 16-bit saturating counter walk_count of completed walks (error or not), cleared only by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package tree_pkg:
  - node field offsets and widths as localparams.
  - state enum typedef (IDLE, FETCH, EVAL, DONE).
  - a function for the float ordering key.
- One sub-module, tree_node_eval: combinational node decode, feature mux, compare and next-address/error generation. The FSM and registers stay in tree_walker.

Test Plan:
- Root leaf: ROM[0] is_leaf=1, class=5; start → res_valid after 3 cycles, res_class=5, res_error=0, res_depth=1.
- Three-level tree: ROM[0] feat 2, threshold 0x40000000 (2.0), left 1, right 2.
  - feature[2]=0x3F800000 (1.0) → visits 0,1; class from ROM[1].
  - feature[2]=0xC0400000 (-3.0) → left branch.
  - feature[2]=0x40400000 (3.0) → right branch.
- Threshold equality: feature == threshold → left child taken; feature = threshold+1 LSB → right child.
- Errors:
  - Internal ROM[0] with left_child=0 → res_error=1, res_class=0.
  - A node self-loop (ROM[1] left=1) → res_error after MAX_DEPTH visits (65 cycles from start at MAX_DEPTH=32).
- Backpressure: hold res_ready=0 for 10 cycles → res_valid/res_class stable, start pulses ignored, busy=1; release → IDLE next cycle.
- Reset mid-walk: deassert rst_n during FETCH → all outputs 0 asynchronously; a new start after reset walks correctly from root.
